// File: rtl/mic1_io_pkg.sv
// Shared definitions for the mic1 memory-mapped UART: default register addresses,
// status register bit positions and the state encoding used by both serial engines.
package mic1_io_pkg;

    localparam logic [31:0] IO_ADDR_DEFAULT     = 32'hFFFF_FFFD;
    localparam logic [31:0] STATUS_ADDR_DEFAULT = 32'hFFFF_FFFC;

    localparam int STAT_RX_AVAIL  = 0;
    localparam int STAT_TX_FULL   = 1;
    localparam int STAT_FRAME_ERR = 2;
    localparam int STAT_OVERRUN   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/mic1_uart_io_if.sv
// CPU data-memory port as seen by the UART responder; the CPU side is the master.
interface mic1_uart_io_if;

    logic        run;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        io_sel;
    logic [31:0] io_rdata;

    modport master (
        output run, mem_read, mem_write, mem_addr, mem_wdata,
        input  io_sel, io_rdata
    );

    modport slave (
        input  run, mem_read, mem_write, mem_addr, mem_wdata,
        output io_sel, io_rdata
    );

endinterface

// File: rtl/io_byte_fifo.sv
// Byte-wide synchronous FIFO with a combinational head. A pop frees a slot in the
// same cycle, so push+pop on a full FIFO both succeed; an empty FIFO never bypasses.
module io_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mic1_uart_io.sv
// Memory-mapped 8N1 UART responder for the mic1 data port: bus decode, status flags,
// TX serialiser and RX deserialiser, each engine fed by its own byte FIFO.
module mic1_uart_io
    import mic1_io_pkg::*;
#(
    parameter logic [31:0] IO_ADDR     = IO_ADDR_DEFAULT,
    parameter logic [31:0] STATUS_ADDR = STATUS_ADDR_DEFAULT,
    parameter int          CLK_HZ      = 50_000_000,
    parameter int          BAUD        = 115_200,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    mic1_uart_io_if.slave        bus,
    input  logic                 uart_rx,
    output logic                 uart_tx
);

    localparam int            CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int            CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT     = CW'(CLKS_PER_BIT / 2 - 1);

    logic hit_io, hit_status;
    logic rd_q, wr_q;
    logic rd_first, wr_first;
    logic rd_io, rd_status, wr_io;
    logic frame_err, overrun;
    logic frame_set, overrun_set;
    logic [3:0] status_bits;

    logic       tx_full, tx_empty, tx_pop;
    logic [7:0] tx_head;
    logic       rx_full, rx_empty, rx_push_req;
    logic [7:0] rx_head;

    uart_state_t   tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic          tx_line_n;

    uart_state_t   rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic          rx_sync1, rx_sync2, rx_prev;

    logic unused_wdata;
    assign unused_wdata = ^bus.mem_wdata[31:8];

    assign hit_io     = (bus.mem_addr == IO_ADDR);
    assign hit_status = (bus.mem_addr == STATUS_ADDR);
    assign bus.io_sel = hit_io | hit_status;

    // Side effects fire only on the rising edge of a strobe, so held strobes act once.
    assign rd_first  = bus.run & bus.mem_read  & ~rd_q;
    assign wr_first  = bus.run & bus.mem_write & ~wr_q;
    assign rd_io     = rd_first & hit_io;
    assign rd_status = rd_first & hit_status;
    assign wr_io     = wr_first & hit_io;

    always_comb begin
        status_bits                 = '0;
        status_bits[STAT_RX_AVAIL]  = ~rx_empty;
        status_bits[STAT_TX_FULL]   = tx_full;
        status_bits[STAT_FRAME_ERR] = frame_err;
        status_bits[STAT_OVERRUN]   = overrun;
    end

    assign overrun_set = rx_push_req & rx_full & ~rd_io;

    // New errors take priority over the status read that clears them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            bus.io_rdata <= '0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            rd_q      <= bus.mem_read;
            wr_q      <= bus.mem_write;
            frame_err <= frame_set   | (frame_err & ~rd_status);
            overrun   <= overrun_set | (overrun   & ~rd_status);
            if (rd_io)
                bus.io_rdata <= {24'b0, (rx_empty ? 8'h00 : rx_head)};
            else if (rd_status)
                bus.io_rdata <= {28'b0, status_bits};
        end
    end

    io_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (wr_io),
        .push_data (bus.mem_wdata[7:0]),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    io_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (rx_push_req),
        .push_data (rx_shift),
        .pop       (rd_io),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // TX: the line level is computed from the next state so uart_tx comes straight off a flop.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        tx_line_n  = 1'b1;
        case (tx_state)
            IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_head;
                    tx_cnt_n   = '0;
                    tx_state_n = START;
                end
            end
            START: begin
                if (tx_cnt == LAST_CNT) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = DATA;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            DATA: begin
                if (tx_cnt == LAST_CNT) begin
                    tx_cnt_n = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_n = STOP;
                    end else begin
                        tx_bit_n   = tx_bit + 1'b1;
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            STOP: begin
                if (tx_cnt == LAST_CNT) begin
                    tx_cnt_n = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_n = tx_head;
                        tx_state_n = START;
                    end else begin
                        tx_state_n = IDLE;
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            default: tx_state_n = IDLE;
        endcase
        case (tx_state_n)
            START:   tx_line_n = 1'b0;
            DATA:    tx_line_n = tx_shift_n[0];
            default: tx_line_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            uart_tx  <= tx_line_n;
        end
    end

    // RX: start is confirmed half a bit after the falling edge; later samples land mid-bit.
    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt;
        rx_bit_n    = rx_bit;
        rx_shift_n  = rx_shift;
        rx_push_req = 1'b0;
        frame_set   = 1'b0;
        case (rx_state)
            IDLE: begin
                if (rx_prev && !rx_sync2) begin
                    rx_cnt_n   = '0;
                    rx_state_n = START;
                end
            end
            START: begin
                if (rx_cnt == HALF_CNT) begin
                    rx_cnt_n = '0;
                    rx_bit_n = '0;
                    rx_state_n = rx_sync2 ? IDLE : DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            DATA: begin
                if (rx_cnt == LAST_CNT) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_sync2, rx_shift[7:1]};
                    if (rx_bit == 3'd7)
                        rx_state_n = STOP;
                    else
                        rx_bit_n = rx_bit + 1'b1;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            STOP: begin
                if (rx_cnt == LAST_CNT) begin
                    rx_cnt_n    = '0;
                    rx_state_n  = IDLE;
                    rx_push_req = rx_sync2;
                    frame_set   = ~rx_sync2;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            default: rx_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_sync1 <= uart_rx;
            rx_sync2 <= rx_sync1;
            rx_prev  <= rx_sync2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

endmodule

// File: tb/tb_mic1_uart_io.sv
// Directed bench for mic1_uart_io at 8 clocks per bit: bus reads/writes, TX frames,
// RX frames, FIFO limits, error flags, held strobes, run gating and mid-frame reset.
module tb_mic1_uart_io;

    localparam logic [31:0] IO_A   = 32'hFFFF_FFFD;
    localparam logic [31:0] STAT_A = 32'hFFFF_FFFC;

    logic clk;
    logic resetn;
    logic uart_rx;
    logic uart_tx;
    int   num_checks;
    int   num_fail;

    mic1_uart_io_if bus_if ();

    mic1_uart_io #(
        .IO_ADDR     (IO_A),
        .STATUS_ADDR (STAT_A),
        .CLK_HZ      (8),
        .BAUD        (1),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .bus     (bus_if),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One bus access with a single-cycle strobe; read data is sampled the cycle after.
    task automatic applyStimulus(input bit is_write, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata);
        @(negedge clk);
        bus_if.mem_addr  = addr;
        bus_if.mem_wdata = wdata;
        bus_if.mem_read  = ~is_write;
        bus_if.mem_write = is_write;
        @(negedge clk);
        bus_if.mem_read  = 1'b0;
        bus_if.mem_write = 1'b0;
        rdata = bus_if.io_rdata;
    endtask

    // frame[0] is the start bit, frame[8:1] the data LSB first, frame[9] the stop bit.
    task automatic capture_tx(output logic [9:0] frame, output bit found);
        found = 1'b0;
        frame = '0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clk);
            if (uart_tx == 1'b0) found = 1'b1;
        end
        if (found) begin
            repeat (4) @(negedge clk);
            frame[0] = uart_tx;
            for (int b = 1; b < 10; b++) begin
                repeat (8) @(negedge clk);
                frame[b] = uart_tx;
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] data, input logic stop_bit);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            uart_rx = data[b];
            repeat (8) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (8) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    logic [31:0] rd;
    logic [9:0]  frame;
    bit          found;
    logic [9:0]  burst_frame [9];
    bit          burst_found [9];
    logic [7:0]  burst_data  [10] = '{8'hA0, 8'h5A, 8'h01, 8'hFF, 8'h3C,
                                      8'h80, 8'h7E, 8'h12, 8'hC9, 8'hEE};
    bit          seen_low;

    initial begin
        num_checks       = 0;
        num_fail         = 0;
        resetn           = 1'b0;
        uart_rx          = 1'b1;
        bus_if.run       = 1'b1;
        bus_if.mem_read  = 1'b0;
        bus_if.mem_write = 1'b0;
        bus_if.mem_addr  = 32'h0;
        bus_if.mem_wdata = 32'h0;
        $display("[TB] start");

        repeat (3) @(negedge clk);
        checkOutput("reset_uart_tx", {31'b0, uart_tx}, 32'h1);
        checkOutput("reset_io_rdata", bus_if.io_rdata, 32'h0);
        resetn = 1'b1;
        applyStimulus(1'b0, STAT_A, 32'h0, rd);
        checkOutput("reset_status", rd, 32'h0);

        bus_if.mem_addr = IO_A;   #1 checkOutput("io_sel_data", {31'b0, bus_if.io_sel}, 32'h1);
        bus_if.mem_addr = STAT_A; #1 checkOutput("io_sel_status", {31'b0, bus_if.io_sel}, 32'h1);
        bus_if.mem_addr = 32'hFFFF_FFFE; #1 checkOutput("io_sel_miss", {31'b0, bus_if.io_sel}, 32'h0);

        // Single TX byte: 0x41 must appear as 0,1,0,0,0,0,0,1,0,1.
        applyStimulus(1'b1, IO_A, 32'hFFFF_FF41, rd);
        capture_tx(frame, found);
        checkOutput("tx41_start_seen", {31'b0, found}, 32'h1);
        checkOutput("tx41_frame", {22'b0, frame}, {22'b0, 10'b1010000010});
        repeat (20) @(negedge clk);
        checkOutput("tx41_idle_after", {31'b0, uart_tx}, 32'h1);

        // Single RX byte, then empty read.
        send_rx(8'h33, 1'b1);
        applyStimulus(1'b0, STAT_A, 32'h0, rd);
        checkOutput("rx33_status", rd, 32'h1);
        applyStimulus(1'b0, IO_A, 32'h0, rd);
        checkOutput("rx33_data", rd, 32'h33);
        applyStimulus(1'b0, IO_A, 32'h0, rd);
        checkOutput("rx_empty_read", rd, 32'h0);

        // Ten writes while idle: one in flight, eight queued, tenth dropped.
        fork
            begin
                for (int i = 0; i < 10; i++) applyStimulus(1'b1, IO_A, {24'b0, burst_data[i]}, rd);
                applyStimulus(1'b0, STAT_A, 32'h0, rd);
                checkOutput("tx_burst_full_status", rd, 32'h2);
            end
            begin
                for (int i = 0; i < 9; i++) capture_tx(burst_frame[i], burst_found[i]);
            end
        join
        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("tx_burst_seen_%0d", i), {31'b0, burst_found[i]}, 32'h1);
            checkOutput($sformatf("tx_burst_frame_%0d", i), {22'b0, burst_frame[i]},
                        {22'b0, 1'b1, burst_data[i], 1'b0});
        end
        repeat (100) @(negedge clk);
        checkOutput("tx_burst_drained", {31'b0, uart_tx}, 32'h1);
        applyStimulus(1'b0, STAT_A, 32'h0, rd);
        checkOutput("tx_burst_status_after", rd, 32'h0);

        // Nine received bytes with no reads: ninth overruns.
        for (int i = 0; i < 9; i++) send_rx(8'h60 + 8'(i), 1'b1);
        applyStimulus(1'b0, STAT_A, 32'h0, rd);
        checkOutput("overrun_status", rd, 32'h9);
        applyStimulus(1'b0, STAT_A, 32'h0, rd);
        checkOutput("overrun_cleared", rd, 32'h1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, IO_A, 32'h0, rd);
            checkOutput($sformatf("overrun_data_%0d", i), rd, 32'h60 + i);
        end
        applyStimulus(1'b0, IO_A, 32'h0, rd);
        checkOutput("overrun_drained", rd, 32'h0);

        // Framing error, then a short glitch.
        send_rx(8'h55, 1'b0);
        applyStimulus(1'b0, STAT_A, 32'h0, rd);
        checkOutput("frame_err_status", rd, 32'h4);
        applyStimulus(1'b0, IO_A, 32'h0, rd);
        checkOutput("frame_err_no_byte", rd, 32'h0);
        applyStimulus(1'b0, STAT_A, 32'h0, rd);
        checkOutput("frame_err_cleared", rd, 32'h0);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (120) @(negedge clk);
        applyStimulus(1'b0, STAT_A, 32'h0, rd);
        checkOutput("glitch_status", rd, 32'h0);

        // Held read pops once.
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        @(negedge clk);
        bus_if.mem_addr = IO_A;
        bus_if.mem_read = 1'b1;
        repeat (3) @(negedge clk);
        bus_if.mem_read = 1'b0;
        checkOutput("held_read_data", bus_if.io_rdata, 32'h11);

        // run low: no pop, no rdata update, no TX push.
        bus_if.run = 1'b0;
        applyStimulus(1'b0, IO_A, 32'h0, rd);
        checkOutput("run0_rdata_held", rd, 32'h11);
        applyStimulus(1'b1, IO_A, 32'h77, rd);
        bus_if.run = 1'b1;
        applyStimulus(1'b0, IO_A, 32'h0, rd);
        checkOutput("held_read_second", rd, 32'h22);
        applyStimulus(1'b0, IO_A, 32'h0, rd);
        checkOutput("held_read_empty", rd, 32'h0);
        seen_low = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (uart_tx == 1'b0) seen_low = 1'b1;
        end
        checkOutput("run0_no_tx", {31'b0, seen_low}, 32'h0);

        // Reset during bit 2 (a zero) of 0xC3 forces the line high at once.
        applyStimulus(1'b1, IO_A, 32'hC3, rd);
        applyStimulus(1'b1, IO_A, 32'h99, rd);
        repeat (26) @(negedge clk);
        checkOutput("mid_tx_line_low", {31'b0, uart_tx}, 32'h0);
        #2 resetn = 1'b0;
        #1 checkOutput("async_reset_tx_high", {31'b0, uart_tx}, 32'h1);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        applyStimulus(1'b0, STAT_A, 32'h0, rd);
        checkOutput("post_reset_status", rd, 32'h0);
        seen_low = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (uart_tx == 1'b0) seen_low = 1'b1;
        end
        checkOutput("post_reset_tx_fifo_empty", {31'b0, seen_low}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
